// File: rtl/bus_pkg.sv
// Shared definitions for bus initiators: device codes, address map, FSM states.
package bus_pkg;

    localparam logic [2:0] DEV_NONE = 3'd0;
    localparam logic [2:0] DEV_RAM  = 3'd1;
    localparam logic [2:0] DEV_UART = 3'd2;

    localparam logic [15:0] RAM_LO  = 16'h0000;
    localparam logic [15:0] RAM_HI  = 16'h00EF;
    localparam logic [15:0] UART_LO = 16'h00F0;
    localparam logic [15:0] UART_HI = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: byte address to device code plus mapped flag.
module bus_addr_decode
    import bus_pkg::*;
(
    input  logic [15:0] addr,
    output logic [2:0]  device,
    output logic        mapped
);

    // RAM_LO is zero, so only the upper bound needs a compare
    always_comb begin
        device = DEV_NONE;
        mapped = 1'b0;
        if (addr <= RAM_HI) begin
            device = DEV_RAM;
            mapped = 1'b1;
        end else if (addr >= UART_LO && addr <= UART_HI) begin
            device = DEV_UART;
            mapped = 1'b1;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// Single-transfer bus initiator: request/response handshake in front of a
// SETUP/ACCESS strobed device bus with programmable wait states.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  device_select,
    output logic [15:0] addr_out,
    output logic        we,
    output logic        oe,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic        write_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [2:0]  dev_q;
    logic [7:0]  rdata_q;
    logic        err_q;
    logic [2:0]  dec_dev;
    logic        dec_mapped;
    logic        accept;
    logic        last;

    bus_addr_decode u_dec (
        .addr   (req_addr),
        .device (dec_dev),
        .mapped (dec_mapped)
    );

    assign accept = req_valid && (state == IDLE);
    assign last   = (state == ACCESS) && (cnt == 3'd0);

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        device_select = DEV_NONE;
        we            = 1'b0;
        oe            = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = dec_mapped ? SETUP : RESP;
            end
            SETUP: begin
                device_select = dev_q;
                state_nx      = ACCESS;
            end
            ACCESS: begin
                device_select = dev_q;
                // gated by rst so an aborting edge never lands a write
                we = write_q && last && !rst;
                oe = !write_q && !rst;
                if (last)
                    state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            write_q <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            dev_q   <= DEV_NONE;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                dev_q   <= dec_dev;
                err_q   <= !dec_mapped;
                rdata_q <= 8'h00;
                cnt     <= WS;
            end else if (state == ACCESS) begin
                if (cnt != 3'd0)
                    cnt <= cnt - 3'd1;
                else if (!write_q)
                    rdata_q <= bus_rdata;
            end
        end
    end

    assign addr_out  = addr_q;
    assign bus_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: two instances (0 and 3 wait states),
// each with its own RAM/UART model on the device bus.
module tb_bus_initiator;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic req_valid = 1'b0;
    logic req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0] req_wdata = 8'h0;
    logic rsp_ready = 1'b0;

    logic rr0, rv0, re0, we0, oe0;
    logic rr1, rv1, re1, we1, oe1;
    logic [7:0] rd0, bw0, br0, rd1, bw1, br1;
    logic [2:0] ds0, ds1;
    logic [15:0] ao0, ao1;
    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];

    int total = 0;
    int bad = 0;
    int sel_cnt, we_cnt, oe_cnt, we_pos;
    logic [2:0] dev_seen;
    int lat;

    always #5 clk = ~clk;

    bus_initiator #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(rr0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(rd0), .rsp_err(re0),
        .device_select(ds0), .addr_out(ao0), .we(we0), .oe(oe0),
        .bus_wdata(bw0), .bus_rdata(br0)
    );

    bus_initiator #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(rr1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(rd1), .rsp_err(re1),
        .device_select(ds1), .addr_out(ao1), .we(we1), .oe(oe1),
        .bus_wdata(bw1), .bus_rdata(br1)
    );

    // device models: RAM below 0xF0, UART status register reads 0x03
    assign br0 = (ds0 == DEV_RAM) ? ram0[ao0[7:0]] :
                 (ds0 == DEV_UART) ? 8'h03 : 8'h00;
    assign br1 = (ds1 == DEV_RAM) ? ram1[ao1[7:0]] :
                 (ds1 == DEV_UART) ? 8'h03 : 8'h00;

    always @(posedge clk) begin
        if (we0 && ds0 == DEV_RAM) ram0[ao0[7:0]] <= bw0;
        if (we1 && ds1 == DEV_RAM) ram1[ao1[7:0]] <= bw1;
    end

    wire o_rr = sel ? rr1 : rr0;
    wire o_rv = sel ? rv1 : rv0;
    wire o_re = sel ? re1 : re0;
    wire o_we = sel ? we1 : we0;
    wire o_oe = sel ? oe1 : oe0;
    wire [7:0] o_rd = sel ? rd1 : rd0;
    wire [7:0] o_bw = sel ? bw1 : bw0;
    wire [2:0] o_ds = sel ? ds1 : ds0;
    wire [15:0] o_ao = sel ? ao1 : ao0;

    always @(negedge clk) begin
        if (o_ds != DEV_NONE) begin
            sel_cnt++;
            dev_seen = o_ds;
        end
        if (o_we) begin
            we_cnt++;
            we_pos = sel_cnt;
        end
        if (o_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // lat counts edges from the accept edge (1) to the edge entering RESP
    task automatic xfer(input string tag, input logic w,
                        input logic [15:0] a, input logic [7:0] d,
                        input int hold, input int exp_lat,
                        input logic [7:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        check({tag, "_req_ready"}, 32'(o_rr), 32'd1);
        @(posedge clk);
        sel_cnt = 0; we_cnt = 0; oe_cnt = 0; we_pos = 0;
        dev_seen = DEV_NONE;
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!o_rv && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(o_rd), 32'(exp_rd));
        check({tag, "_err"}, 32'(o_re), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 16'h1234;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(o_rv), 32'd1);
            check({tag, "_hold_rdata"}, 32'(o_rd), 32'(exp_rd));
            check({tag, "_hold_err"}, 32'(o_re), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(o_rr), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check({tag, "_ready_in_resp"}, 32'(o_rr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_after"}, 32'(o_rv), 32'd0);
        check({tag, "_ready_after"}, 32'(o_rr), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram0[i] = 8'h00;
            ram1[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(o_rr), 32'd1);
        check("rst_rsp_valid", 32'(o_rv), 32'd0);
        check("rst_rsp_rdata", 32'(o_rd), 32'd0);
        check("rst_rsp_err", 32'(o_re), 32'd0);
        check("rst_dev", 32'(o_ds), 32'd0);
        check("rst_addr_out", 32'(o_ao), 32'd0);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_oe", 32'(o_oe), 32'd0);
        check("rst_bus_wdata", 32'(o_bw), 32'd0);
        rst = 1'b0;

        xfer("wr42", 1'b1, 16'h0042, 8'hA5, 0, 3, 8'h00, 1'b0);
        check("wr42_we_cycles", 32'(we_cnt), 32'd1);
        check("wr42_oe_cycles", 32'(oe_cnt), 32'd0);
        check("wr42_ram", 32'(ram0[8'h42]), 32'h00A5);

        xfer("rd42", 1'b0, 16'h0042, 8'h00, 0, 3, 8'hA5, 1'b0);
        check("rd42_oe_cycles", 32'(oe_cnt), 32'd1);
        check("rd42_we_cycles", 32'(we_cnt), 32'd0);
        check("rd42_dev", 32'(dev_seen), 32'(DEV_RAM));

        xfer("uart", 1'b0, 16'h00F0, 8'h00, 0, 3, 8'h03, 1'b0);
        check("uart_dev", 32'(dev_seen), 32'(DEV_UART));

        xfer("rdef", 1'b0, 16'h00EF, 8'h00, 0, 3, 8'h00, 1'b0);
        check("rdef_dev", 32'(dev_seen), 32'(DEV_RAM));

        xfer("unmap", 1'b0, 16'h1234, 8'h00, 0, 1, 8'h00, 1'b1);
        check("unmap_oe", 32'(oe_cnt), 32'd0);
        check("unmap_we", 32'(we_cnt), 32'd0);
        check("unmap_sel", 32'(sel_cnt), 32'd0);

        xfer("unmap100", 1'b1, 16'h0100, 8'h11, 0, 1, 8'h00, 1'b1);
        check("unmap100_we", 32'(we_cnt), 32'd0);

        xfer("stall", 1'b0, 16'h0042, 8'h00, 5, 3, 8'hA5, 1'b0);

        sel = 1'b1;
        xfer("ws3_wr", 1'b1, 16'h0010, 8'h5A, 0, 6, 8'h00, 1'b0);
        check("ws3_sel_cycles", 32'(sel_cnt), 32'd5);
        check("ws3_we_cycles", 32'(we_cnt), 32'd1);
        check("ws3_we_pos", 32'(we_pos), 32'd5);
        check("ws3_ram", 32'(ram1[8'h10]), 32'h005A);
        xfer("ws3_rd", 1'b0, 16'h0010, 8'h00, 0, 6, 8'h5A, 1'b0);
        check("ws3_oe_cycles", 32'(oe_cnt), 32'd4);
        sel = 1'b0;

        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 16'h0050;
        req_wdata = 8'h77;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_dev_access", 32'(o_ds), 32'(DEV_RAM));
        check("abort_we_before", 32'(o_we), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_gated", 32'(o_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", 32'(o_rr), 32'd1);
        check("abort_rsp_valid", 32'(o_rv), 32'd0);
        check("abort_dev", 32'(o_ds), 32'd0);
        check("abort_ram", 32'(ram0[8'h50]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(o_rv), 32'd0);
        end
        xfer("after_abort", 1'b0, 16'h0050, 8'h00, 0, 3, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
